// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU byte path and word memory.
// Defining DCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module dcache_controller #(
    parameter int INDEX_BITS = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_address,
    input  logic [7:0]  cpu_writedata,
    output logic [7:0]  cpu_readdata,
    output logic        cpu_busywait,
`ifdef DCACHE_STATS_EN
    output logic [15:0] hit_count,
    output logic [15:0] miss_count,
`endif
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
);

    localparam int TAG_BITS = 6 - INDEX_BITS;
    localparam int SETS     = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WRITE_BACK, MEM_READ, UPDATE} state_t;

    state_t state, next_state;

    logic [SETS-1:0]     valid;
    logic [SETS-1:0]     dirty;
    logic [TAG_BITS-1:0] tags   [SETS];
    logic [31:0]         blocks [SETS];
    logic [7:0]          last_read;

    logic [TAG_BITS-1:0]   cpu_tag;
    logic [INDEX_BITS-1:0] index;
    logic [4:0]            bit_offset;
    logic [7:0]            line_byte;
    logic                  request, hit, read_hit, write_hit, miss;

    assign cpu_tag    = cpu_address[7 -: TAG_BITS];
    assign index      = cpu_address[2 +: INDEX_BITS];
    assign bit_offset = {cpu_address[1:0], 3'b000};
    assign line_byte  = blocks[index][bit_offset +: 8];

    // Both strobes high is treated as no request at all.
    assign request   = cpu_read ^ cpu_write;
    assign hit       = valid[index] && (tags[index] == cpu_tag);
    assign read_hit  = (state == IDLE) && cpu_read && !cpu_write && hit;
    assign write_hit = (state == IDLE) && cpu_write && !cpu_read && hit;
    assign miss      = reset && (state == IDLE) && request && !hit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (miss) next_state = (valid[index] && dirty[index]) ? WRITE_BACK : MEM_READ;
            WRITE_BACK: if (!mem_busywait) next_state = MEM_READ;
            MEM_READ:   if (!mem_busywait) next_state = UPDATE;
            UPDATE:     next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        cpu_busywait  = 1'b0;
        case (state)
            IDLE:       cpu_busywait = miss;
            WRITE_BACK: begin
                mem_write     = 1'b1;
                mem_address   = {tags[index], index};
                mem_writedata = blocks[index];
                cpu_busywait  = 1'b1;
            end
            MEM_READ:   begin
                mem_read     = 1'b1;
                mem_address  = {cpu_tag, index};
                cpu_busywait = 1'b1;
            end
            UPDATE:     cpu_busywait = 1'b1;
            default:    cpu_busywait = 1'b0;
        endcase
    end

    // The load output keeps the last delivered byte whenever no read hit is being served.
    assign cpu_readdata = read_hit ? line_byte : last_read;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid     <= '0;
            dirty     <= '0;
            last_read <= '0;
            for (int i = 0; i < SETS; i++) begin
                tags[i]   <= '0;
                blocks[i] <= '0;
            end
        end else begin
            if (write_hit) begin
                blocks[index][bit_offset +: 8] <= cpu_writedata;
                dirty[index]                   <= 1'b1;
            end else if (state == UPDATE) begin
                blocks[index] <= mem_readdata;
                tags[index]   <= cpu_tag;
                valid[index]  <= 1'b1;
                dirty[index]  <= 1'b0;
            end
            if (read_hit) last_read <= line_byte;
        end
    end

`ifdef DCACHE_STATS_EN
    // The hit that finishes a refilled access arrives in the first IDLE cycle after UPDATE and is not a new hit.
    logic refilled;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
            refilled   <= 1'b0;
        end else begin
            refilled <= (state == UPDATE);
            if ((read_hit || write_hit) && !refilled && (hit_count != 16'hFFFF))
                hit_count <= hit_count + 16'd1;
            if (miss && (miss_count != 16'hFFFF))
                miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: a latency-configurable word memory, a coherent byte
// shadow of memory plus a tag/valid/dirty line model predicting stalls and memory transactions.
module tb_dcache_controller;

    typedef struct {
        logic        isWrite;
        logic [5:0]  addr;
        logic [31:0] data;
    } memTxn_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_read, cpu_write;
    logic [7:0]  cpu_address, cpu_writedata, cpu_readdata;
    logic        cpu_busywait;
    logic        mem_read, mem_write, mem_busywait;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata, mem_readdata;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    int testsRun = 0;
    int testsFailed = 0;
    int memLatency = 2;
    int memCnt;
    int overlapCount = 0;
    int violationCount = 0;
    int expHits = 0;
    int expMisses = 0;
    int lastReadCycles = 0;

    logic [31:0] memWords [64];
    logic [31:0] readReg;
    logic        memInitDone = 1'b0;

    logic [7:0]  shadow [256];
    logic        lineValid [8];
    logic        lineDirty [8];
    logic [2:0]  lineTag [8];

    logic [7:0]  expRead [$];
    memTxn_t     expMem [$];

    logic [1:0]  prevStrobes = 2'b00;
    logic        prevDone = 1'b0;
    logic        prevBusy = 1'b0;
    logic [17:0] prevCpu = '0;

    dcache_controller dut (
        .clock         (clock),
        .reset         (reset),
        .cpu_read      (cpu_read),
        .cpu_write     (cpu_write),
        .cpu_address   (cpu_address),
        .cpu_writedata (cpu_writedata),
        .cpu_readdata  (cpu_readdata),
        .cpu_busywait  (cpu_busywait),
`ifdef DCACHE_STATS_EN
        .hit_count     (hit_count),
        .miss_count    (miss_count),
`endif
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] initByte(input int a);
        int v;
        v = (a * 37 + 11) % 256;
        return v[7:0];
    endfunction

    // Word memory: busy for memLatency cycles of each transaction, read data held in a register.
    assign mem_busywait = (mem_read || mem_write) && (memCnt < memLatency);
    assign mem_readdata = readReg;

    always @(posedge clock) begin
        if (!memInitDone) begin
            for (int w = 0; w < 64; w++)
                for (int k = 0; k < 4; k++)
                    memWords[w][8*k +: 8] <= initByte(w * 4 + k);
            readReg     <= '0;
            memCnt      <= 0;
            memInitDone <= 1'b1;
        end else begin
            if ((mem_read || mem_write) && mem_busywait) memCnt <= memCnt + 1;
            else                                         memCnt <= 0;
            if (mem_read && !mem_busywait)  readReg <= memWords[mem_address];
            if (mem_write && !mem_busywait) memWords[mem_address] <= mem_writedata;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Memory monitor: compares each new transaction against the expected queue, tracks protocol errors.
    always @(negedge clock) begin
        #2;
        if (mem_read && mem_write) overlapCount++;
        if ({mem_write, mem_read} != 2'b00 && ({mem_write, mem_read} != prevStrobes || prevDone)) begin
            if (expMem.size() == 0) begin
                checkOutput("memUnexpected", {25'd0, mem_write, mem_address}, 32'hFFFF_FFFF);
            end else begin
                memTxn_t t;
                t = expMem.pop_front();
                checkOutput("memKind", {31'd0, mem_write}, {31'd0, t.isWrite});
                checkOutput("memAddr", {26'd0, mem_address}, {26'd0, t.addr});
                if (t.isWrite) checkOutput("memWdata", mem_writedata, t.data);
            end
        end
        prevDone    = ({mem_write, mem_read} != 2'b00) && !mem_busywait;
        prevStrobes = {mem_write, mem_read};
        if (cpu_busywait && prevBusy && ({cpu_read, cpu_write, cpu_address, cpu_writedata} != prevCpu))
            violationCount++;
        prevBusy = cpu_busywait;
        prevCpu  = {cpu_read, cpu_write, cpu_address, cpu_writedata};
    end

    task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] data);
        logic [2:0] idx;
        logic [2:0] tg;
        logic [7:0] base;
        memTxn_t    t;
        int         expStall;
        int         stall;
        int         readCycles;
        idx        = addr[4:2];
        tg         = addr[7:5];
        expStall   = 0;
        stall      = 0;
        readCycles = 0;
        @(negedge clock);
        cpu_read      = rd;
        cpu_write     = wr;
        cpu_address   = addr;
        cpu_writedata = data;
        if (rd ^ wr) begin
            if (lineValid[idx] && lineTag[idx] == tg) begin
                expHits++;
            end else begin
                expMisses++;
                if (lineValid[idx] && lineDirty[idx]) begin
                    base      = {lineTag[idx], idx, 2'b00};
                    t.isWrite = 1'b1;
                    t.addr    = {lineTag[idx], idx};
                    t.data    = {shadow[base + 8'd3], shadow[base + 8'd2], shadow[base + 8'd1], shadow[base]};
                    expMem.push_back(t);
                    expStall = 2 * memLatency + 4;
                end else begin
                    expStall = memLatency + 3;
                end
                t.isWrite = 1'b0;
                t.addr    = {tg, idx};
                t.data    = '0;
                expMem.push_back(t);
                lineValid[idx] = 1'b1;
                lineTag[idx]   = tg;
                lineDirty[idx] = 1'b0;
            end
            if (rd) begin
                expRead.push_back(shadow[addr]);
            end else begin
                shadow[addr]   = data;
                lineDirty[idx] = 1'b1;
            end
        end
        #1;
        while (cpu_busywait && stall < 100) begin
            stall++;
            if (mem_read) readCycles++;
            @(negedge clock);
            #1;
        end
        checkOutput($sformatf("stall@%02h", addr), stall, expStall);
        if (rd && !wr) begin
            if (expRead.size() == 0) checkOutput("loadQueueEmpty", 32'd1, 32'd0);
            else checkOutput($sformatf("load@%02h", addr), {24'd0, cpu_readdata}, {24'd0, expRead.pop_front()});
        end
        lastReadCycles = readCycles;
        @(posedge clock);
        #1;
    endtask

`ifdef DCACHE_STATS_EN
    task automatic checkStats();
        checkOutput("hitCount", {16'd0, hit_count}, expHits);
        checkOutput("missCount", {16'd0, miss_count}, expMisses);
    endtask
`endif

    task automatic clearLineModel();
        for (int i = 0; i < 8; i++) begin
            lineValid[i] = 1'b0;
            lineDirty[i] = 1'b0;
            lineTag[i]   = 3'd0;
        end
        expHits   = 0;
        expMisses = 0;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) shadow[a] = initByte(a);
        clearLineModel();
        reset         = 1'b0;
        cpu_read      = 1'b0;
        cpu_write     = 1'b0;
        cpu_address   = 8'h00;
        cpu_writedata = 8'h00;

        #2;
        checkOutput("rstBusy", {31'd0, cpu_busywait}, 32'd0);
        checkOutput("rstMemRead", {31'd0, mem_read}, 32'd0);
        checkOutput("rstMemWrite", {31'd0, mem_write}, 32'd0);
        checkOutput("rstReaddata", {24'd0, cpu_readdata}, 32'd0);
        checkOutput("rstMemAddr", {26'd0, mem_address}, 32'd0);
        checkOutput("rstMemWdata", mem_writedata, 32'd0);
        #20;
        @(negedge clock);
        reset = 1'b1;

        // Clean miss, store hit, load hit returning the stored byte.
        applyStimulus(1'b1, 1'b0, 8'h05, 8'h00);
`ifdef DCACHE_STATS_EN
        checkStats();
`endif
        applyStimulus(1'b0, 1'b1, 8'h05, 8'hAB);
        applyStimulus(1'b1, 1'b0, 8'h05, 8'h00);
        @(negedge clock);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        #1;
        checkOutput("holdReaddata", {24'd0, cpu_readdata}, 32'h0000_00AB);

        // Dirty eviction: write-back of block 0x01 then refill of block 0x09.
        applyStimulus(1'b1, 1'b0, 8'h25, 8'h00);

        // Both strobes high must neither stall nor store.
        applyStimulus(1'b1, 1'b0, 8'h10, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h10, 8'hEE);
        applyStimulus(1'b1, 1'b0, 8'h10, 8'h00);
`ifdef DCACHE_STATS_EN
        checkStats();
`endif

        // Reset in the middle of a refill.
        @(negedge clock);
        cpu_read    = 1'b1;
        cpu_write   = 1'b0;
        cpu_address = 8'h45;
        expMem.push_back('{isWrite: 1'b0, addr: 6'h11, data: 32'd0});
        #3;
        for (int i = 0; i < 20 && !mem_read; i++) begin
            @(negedge clock);
            #3;
        end
        checkOutput("midMissMemRead", {31'd0, mem_read}, 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("abortMemRead", {31'd0, mem_read}, 32'd0);
        checkOutput("abortBusy", {31'd0, cpu_busywait}, 32'd0);
        checkOutput("abortMemAddr", {26'd0, mem_address}, 32'd0);
        clearLineModel();
        @(negedge clock);
        cpu_read = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h05, 8'h00);

        // Memory never busy: exactly one cycle spent in MEM_READ.
        memLatency = 0;
        applyStimulus(1'b1, 1'b0, 8'h45, 8'h00);
        checkOutput("fastReadCycles", lastReadCycles, 32'd1);
        memLatency = 2;

        for (int n = 0; n < 24; n++) begin
            logic isRead;
            logic [7:0] a;
            logic [7:0] d;
            isRead = 1'($urandom_range(0, 1));
            a      = 8'($urandom_range(0, 255));
            d      = 8'($urandom_range(0, 255));
            applyStimulus(isRead, !isRead, a, d);
        end
        @(negedge clock);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        repeat (3) @(negedge clock);
        #3;

        checkOutput("memQueueLeft", expMem.size(), 32'd0);
        checkOutput("loadQueueLeft", expRead.size(), 32'd0);
        checkOutput("strobeOverlap", overlapCount, 32'd0);
        checkOutput("inputChangeWhileBusy", violationCount, 32'd0);
`ifdef DCACHE_STATS_EN
        checkStats();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
